// File: rtl/board_scan_tx.sv
// board_scan_tx: reads playfield rows from the board-read port and shifts them out
// to a shift-register LED matrix driver with latch, row select and blanking.
module board_scan_tx #(
    parameter int ROWS     = 20,
    parameter int COLS     = 10,
    parameter int CLK_DIV  = 2,
    parameter int ROW_HOLD = 16
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic            i_en,
    output logic            o_row_rd,
    output logic [4:0]      o_row_addr,
    input  logic [COLS-1:0] i_row_data,
    output logic            o_sdata,
    output logic            o_sclk,
    output logic            o_latch,
    output logic [4:0]      o_row_sel,
    output logic            o_blank,
    output logic            o_busy,
    output logic            o_frame_done
);
    localparam int MAXC = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(ROW_HOLD - 1);
    localparam logic [BW-1:0] BIT_TOP   = BW'(COLS - 1);
    localparam logic [4:0]    ROW_LAST  = 5'(ROWS - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAP, S_SHIFT, S_LATCH, S_HOLD} state_t;

    state_t          r_state;
    logic [4:0]      r_row;
    logic [BW-1:0]   r_bit;
    logic [CW-1:0]   r_cnt;
    logic            r_phase;
    logic [COLS-1:0] r_shreg;

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_bit        <= '0;
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_shreg      <= '0;
            o_row_rd     <= 1'b0;
            o_row_addr   <= '0;
            o_sdata      <= 1'b0;
            o_sclk       <= 1'b0;
            o_latch      <= 1'b0;
            o_row_sel    <= '0;
            o_blank      <= 1'b1;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_state    <= S_REQ;
                        r_row      <= '0;
                        o_row_rd   <= 1'b1;
                        o_row_addr <= '0;
                    end
                end
                S_REQ: begin
                    o_row_rd <= 1'b0;
                    r_state  <= S_CAP;
                end
                S_CAP: begin
                    r_shreg <= i_row_data;
                    o_sdata <= i_row_data[COLS-1];
                    o_sclk  <= 1'b0;
                    r_bit   <= BIT_TOP;
                    r_cnt   <= '0;
                    r_phase <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // each bit: CLK_DIV cycles low with data set up, then CLK_DIV high
                    if (r_cnt == DIV_LAST) begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            o_sclk  <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            o_sclk  <= 1'b0;
                            if (r_bit == '0) begin
                                r_state   <= S_LATCH;
                                o_latch   <= 1'b1;
                                o_row_sel <= r_row;
                            end else begin
                                r_bit   <= r_bit - 1'b1;
                                o_sdata <= r_shreg[r_bit - 1'b1];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        o_latch <= 1'b0;
                        o_blank <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        o_blank <= 1'b1;
                        if (r_row != ROW_LAST) begin
                            r_row      <= r_row + 1'b1;
                            o_row_addr <= r_row + 1'b1;
                            o_row_rd   <= 1'b1;
                            r_state    <= S_REQ;
                        end else begin
                            // en is only consulted here, so a frame always completes
                            o_frame_done <= 1'b1;
                            r_row        <= '0;
                            if (i_en) begin
                                o_row_addr <= '0;
                                o_row_rd   <= 1'b1;
                                r_state    <= S_REQ;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/board_scan_tx.md
Name: board_scan_tx

Overview:
- Reads the playfield one row at a time from the tetris datapath's board-read port.
- Serialises each row to an external shift-register LED matrix driver (data, shift clock, latch, row select, blank).
- Sits beside the tetris datapath in top, on the display side: the datapath writes the board, this block reads it out.
- Runs continuously while enabled; signals frame boundaries so control can synchronise auto-down to refresh.

Parameters:
- ROWS, 20, playfield rows scanned per frame (row 0 first).
- COLS, 10, bits per row; width of row_data.
- CLK_DIV, 2, clk cycles per sclk half-period and latch pulse width (>=1).
- ROW_HOLD, 16, clk cycles each row stays lit after latch (>=1).

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- en  in  1  scan enable; level-sensitive.
- row_rd  out  1  one-cycle read strobe to board-read port.
- row_addr  out  5  row being read; valid while row_rd=1.
- row_data  in  COLS  row contents; valid exactly one cycle after row_rd. Bit i = column i; 1 = occupied.
- sdata  out  1  serial data to LED driver.
- sclk  out  1  shift clock; driver samples on rising edge.
- latch  out  1  driver output-register load pulse.
- row_sel  out  5  row currently driven on the matrix.
- blank  out  1  1 = matrix outputs off.
- busy  out  1  1 whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the last row's hold completes.

Behaviour:
- Reset values (clr=1, takes effect on the next edge, from any state):
  - state=IDLE, row counter=0.
  - row_rd=0, row_addr=0, sdata=0, sclk=0, latch=0, row_sel=0.
  - blank=1, busy=0, frame_done=0.
  - Reset mid-shift abandons the row; no partial latch is issued.
- States: IDLE, REQ, CAP, SHIFT, LATCH, HOLD.
- IDLE:
  - All strobes low, blank=1.
  - If en=1, go to REQ with row=0.
- REQ (1 cycle): row_rd=1, row_addr=row, then go to CAP.
- CAP (1 cycle):
  - Load row_data into a COLS-bit shift register.
  - Set bit index=COLS-1, then go to SHIFT.
  - row_data is sampled only in this cycle.
- SHIFT:
  - For each bit from COLS-1 down to 0:
    - sdata=shreg[bit] with sclk=0 for CLK_DIV cycles.
    - Then sclk=1 for CLK_DIV cycles, with sdata held.
  - sdata changes only while sclk=0.
  - After bit 0's high phase: sclk=0, go to LATCH.
  - Duration = 2*CLK_DIV*COLS cycles.
  - blank=1 throughout; row_sel keeps the previous row.
- LATCH (CLK_DIV cycles):
  - latch=1, blank=1.
  - row_sel updates to row on the first LATCH cycle.
- HOLD (ROW_HOLD cycles):
  - blank=0, latch=0.
  - On the last cycle:
    - If row != ROWS-1: row++, go to REQ.
    - If row = ROWS-1: pulse frame_done on the cycle after the last HOLD cycle, concurrent with entry to the next state.
      - If en=1 at the last HOLD cycle: row wraps to 0, go to REQ.
      - Else go to IDLE.
- en deassertion mid-frame: the current frame always completes; en is only checked at frame end (and in IDLE).
- Row period = 1 + 1 + 2*CLK_DIV*COLS + CLK_DIV + ROW_HOLD.
  - Defaults: 2 + 40 + 2 + 16 = 60 cycles.
  - Frame = ROWS*60 = 1200 cycles.
- First row_rd follows en rise by 1 cycle (IDLE -> REQ on the edge sampling en=1; row_rd high during REQ).
- row_addr holds its last value outside REQ; only the row_rd cycle is meaningful.
- Counters are sized for their maxima (bit index up to COLS-1, div/hold counts up to max(CLK_DIV, ROW_HOLD)). No wrap glitch at maxima.

Test Plan:
- Reset/idle: assert clr 3 cycles during SHIFT with en=1 -> next cycle blank=1, busy=0, sclk=0, latch=0, row_sel=0, row_rd=0; after clr release with en=1, row_rd rises 1 cycle later with row_addr=0.
- Single-row serialisation: model returns row_data=10'b1000000011 for row 0 -> 10 sclk rising edges sample sdata = 1,0,0,0,0,0,0,0,1,1; each sclk high/low phase is 2 clk; latch high 2 cycles; row_sel=0; blank low for exactly 16 cycles.
- Frame timing: en=1 continuously, default parameters -> row_rd pulses every 60 cycles with row_addr 0..19 then 0; frame_done pulses once per 1200 cycles, coincident with the wrap.
- en drop mid-frame: deassert en at row 7 -> rows 8..19 still scanned, frame_done pulses, state returns to IDLE (busy=0, blank=1), no further row_rd.
- Data sampling window: model changes row_data every cycle except the CAP cycle -> shifted pattern equals the CAP-cycle value only; all-ones and all-zeros rows shift 10 ones / 10 zeros.
- Parameter corner: CLK_DIV=1, ROW_HOLD=1, ROWS=2 -> row period 24 cycles, sclk toggles every cycle, frame_done every 48 cycles.
